// File: rtl/ad_scan_ctrl.sv
// Channel-scan sequencer for the AD SPI transceiver: builds per-frame command
// words, gates receive, and tags pipelined conversion results with their channel.
module ad_scan_ctrl #(
  parameter logic [15:0] CMD_BASE = 16'hF120,
  parameter int unsigned CHAN_LSB = 7,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        CS,
  input  logic [15:0] Data_In,
  input  logic        scan_en,
  input  logic [7:0]  chan_mask,
  input  logic [2:0]  rd_chan,
  output logic [15:0] Data_Out,
  output logic        ReadData_Flag,
  output logic        result_valid,
  output logic [2:0]  result_chan,
  output logic [15:0] result_data,
  output logic [15:0] rd_data,
  output logic        busy
);

  localparam int unsigned CHAN_W = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NCHAN  = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic                cs_q;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rdf_q, rdf_d;
  logic                res_vld_q, res_vld_d;
  logic [CHAN_W-1:0]   res_chan_q, res_chan_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [DATA_W-1:0]   file_q [NCHAN];
  logic [DATA_W-1:0]   file_d [NCHAN];
  logic [PIPE_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [CHAN_W-1:0]   tag_chan_q [PIPE_LAT];
  logic [CHAN_W-1:0]   tag_chan_d [PIPE_LAT];
  logic [CHAN_W-1:0]   nxt_q, nxt_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                busy_q, busy_d;

  logic                frame_end;
  logic                sel_found;
  logic [CHAN_W-1:0]   sel_chan;
  logic [CHAN_W-1:0]   search_idx;
  logic                issue;
  logic                push_vld;
  logic [CHAN_W-1:0]   push_chan;

  assign frame_end = CS & ~cs_q;

  // Round-robin pick: first enabled channel at or above the one after the last issued.
  always_comb begin
    sel_found  = 1'b0;
    sel_chan   = '0;
    search_idx = '0;
    for (int i = 0; i < int'(NCHAN); i++) begin
      search_idx = nxt_q + CHAN_W'(i);
      if (!sel_found && chan_mask[search_idx]) begin
        sel_found = 1'b1;
        sel_chan  = search_idx;
      end
    end
  end

  // Frame-end control: retire head tag, step the scan FSM, push the tag for the next command.
  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    rdf_d       = rdf_q;
    res_vld_d   = 1'b0;
    res_chan_d  = res_chan_q;
    res_data_d  = res_data_q;
    file_d      = file_q;
    tag_vld_d   = tag_vld_q;
    tag_chan_d  = tag_chan_q;
    nxt_d       = nxt_q;
    drain_cnt_d = drain_cnt_q;
    issue       = 1'b0;
    push_vld    = 1'b0;
    push_chan   = '0;

    if (frame_end) begin
      if (tag_vld_q[0]) begin
        res_vld_d              = 1'b1;
        res_chan_d             = tag_chan_q[0];
        res_data_d             = Data_In;
        file_d[tag_chan_q[0]]  = Data_In;
      end

      case (state_q)
        ST_IDLE: begin
          if (scan_en) begin
            state_d = ST_RUN;
            rdf_d   = 1'b1;
            issue   = 1'b1;
          end else begin
            data_out_d = CMD_BASE;
          end
        end
        ST_RUN: begin
          if (scan_en) begin
            issue = 1'b1;
          end else begin
            state_d     = ST_DRAIN;
            data_out_d  = CMD_BASE;
            drain_cnt_d = CNT_W'(PIPE_LAT - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_d = ST_IDLE;
            rdf_d   = 1'b0;
          end else begin
            drain_cnt_d = drain_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // An empty mask still issues a command, but with channel 0 and an invalid tag.
      if (issue) begin
        data_out_d = CMD_BASE | (DATA_W'(sel_chan) << CHAN_LSB);
        push_vld   = sel_found;
        push_chan  = sel_chan;
        if (sel_found) begin
          nxt_d = sel_chan + CHAN_W'(1);
        end
      end

      for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
        tag_vld_d[i]  = tag_vld_q[i+1];
        tag_chan_d[i] = tag_chan_q[i+1];
      end
      tag_vld_d[PIPE_LAT-1]  = push_vld;
      tag_chan_d[PIPE_LAT-1] = push_chan;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b1;
      data_out_q  <= CMD_BASE;
      rdf_q       <= 1'b0;
      res_vld_q   <= 1'b0;
      res_chan_q  <= '0;
      res_data_q  <= '0;
      tag_vld_q   <= '0;
      nxt_q       <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < int'(NCHAN); i++) begin
        file_q[i] <= '0;
      end
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        tag_chan_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cs_q        <= CS;
      data_out_q  <= data_out_d;
      rdf_q       <= rdf_d;
      res_vld_q   <= res_vld_d;
      res_chan_q  <= res_chan_d;
      res_data_q  <= res_data_d;
      file_q      <= file_d;
      tag_vld_q   <= tag_vld_d;
      tag_chan_q  <= tag_chan_d;
      nxt_q       <= nxt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign Data_Out      = data_out_q;
  assign ReadData_Flag = rdf_q;
  assign result_valid  = res_vld_q;
  assign result_chan   = res_chan_q;
  assign result_data   = res_data_q;
  assign rd_data       = file_q[rd_chan];
  assign busy          = busy_q;

endmodule
